// File: rtl/vga_pkg.sv
// Shared constants for the 160x120 framebuffer scan-out path.
// 640x480@60 timing, framebuffer geometry and colour bit layout.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_FB_W = 160;
    localparam int VGA_FB_H = 120;

    localparam int COL_R = 2;
    localparam int COL_G = 1;
    localparam int COL_B = 0;

    localparam int ADDR_W = $clog2(VGA_FB_W * VGA_FB_H);
    localparam int CNT_W  = 10;
    localparam int DAC_W  = 10;

    // One stored colour bit drives a whole DAC channel.
    function automatic logic [DAC_W-1:0] expand(input logic b);
        return {DAC_W{b}};
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-phase divider plus horizontal/vertical raster counters.
// Produces the tick strobe, raw sync/active flags and the frame tick.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             tick_o,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             active_o,
    output logic             hs_raw_o,
    output logic             vs_raw_o,
    output logic             frame_tick_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             phase_q, phase_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             frame_q, frame_d;

    // Next raster position; counters only move on a pixel tick.
    always_comb begin
        phase_d  = ~phase_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (phase_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        frame_d = phase_q && (hcount_d == '0) && (vcount_d == V_ACT);
    end

    // Phase, counter and frame-tick state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            frame_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            frame_q  <= frame_d;
        end
    end

    assign tick_o       = phase_q;
    assign hcount_o     = hcount_q;
    assign vcount_o     = vcount_q;
    assign active_o     = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    assign hs_raw_o     = (hcount_q >= HS_LO) && (hcount_q < HS_HI);
    assign vs_raw_o     = (vcount_q >= VS_LO) && (vcount_q < VS_HI);
    assign frame_tick_o = frame_q;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer reader and VGA DAC driver with 4x4 pixel replication.
// Address stage and output stage are each one pixel tick deep.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int FB_W     = VGA_FB_W
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd_en,
    input  logic [2:0]        fb_data,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic [DAC_W-1:0]  VGA_R,
    output logic [DAC_W-1:0]  VGA_G,
    output logic [DAC_W-1:0]  VGA_B,
    output logic              frame_tick
);

    logic             tick;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .tick_o       (tick),
        .hcount_o     (hcount),
        .vcount_o     (vcount),
        .active_o     (active),
        .hs_raw_o     (hs_raw),
        .vs_raw_o     (vs_raw),
        .frame_tick_o (frame_tick)
    );

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              act_q;
    logic              hs_q;
    logic              vs_q;
    logic [DAC_W-1:0]  r_q, g_q, b_q;
    logic              hs_n_q, vs_n_q, blank_n_q;

    // Linear framebuffer index of the 4x4 cell under the beam.
    always_comb begin
        addr_d = '0;
        if (active) begin
            addr_d = ADDR_W'(vcount >> 2) * ADDR_W'(FB_W)
                   + ADDR_W'(hcount >> 2);
        end
    end

    // Address stage: issue the read and delay the raster flags with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            act_q  <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
        end else if (tick) begin
            addr_q <= addr_d;
            act_q  <= active;
            hs_q   <= hs_raw;
            vs_q   <= vs_raw;
        end
    end

    // Output stage: colour expansion gated by the delayed active flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (tick) begin
            r_q       <= expand(act_q & fb_data[COL_R]);
            g_q       <= expand(act_q & fb_data[COL_G]);
            b_q       <= expand(act_q & fb_data[COL_B]);
            hs_n_q    <= ~hs_q;
            vs_n_q    <= ~vs_q;
            blank_n_q <= act_q;
        end
    end

    assign fb_addr     = addr_q;
    assign fb_rd_en    = act_q;
    assign VGA_CLK     = tick;
    assign VGA_HS      = hs_n_q;
    assign VGA_VS      = vs_n_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout with a shortened vertical raster.
// A per-edge reference pushes expectations; a negedge monitor compares.
module tb_vga_scanout;

    localparam int LINE   = 800;
    localparam int V_ACT  = 8;
    localparam int LINES  = 12;
    localparam int FRAME  = LINE * LINES;

    logic        clk;
    logic        resetn;
    logic [14:0] fb_addr;
    logic        fb_rd_en;
    logic [2:0]  fb_data;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0]  VGA_R, VGA_G, VGA_B;
    logic        frame_tick;

    vga_scanout #(
        .V_ACTIVE (V_ACT),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .fb_addr     (fb_addr),
        .fb_rd_en    (fb_rd_en),
        .fb_data     (fb_data),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Framebuffer model: red cell at 161, background elsewhere,
    // junk whenever the read strobe is low.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)             fb_data <= 3'b000;
        else if (!fb_rd_en)      fb_data <= 3'b111;
        else if (fb_addr == 161) fb_data <= 3'b100;
        else                     fb_data <= 3'b011;
    end

    typedef struct packed {
        logic        vclk;
        logic [14:0] addr;
        logic        en;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        sync_n;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
        logic        ft;
    } out_t;

    typedef struct {
        int   e;
        out_t x;
    } sb_t;

    typedef struct packed {
        int          e;
        logic [14:0] a;
        logic        en;
        logic        hs;
    } dv_t;

    sb_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  e_cnt  = 0;
    int  ft_seen = 0;

    // Hand-computed points: clk edge after release -> addr, rd_en, HS.
    dv_t tbl [0:9] = '{
        '{2,     15'd0,   1'b1, 1'b1},
        '{10,    15'd1,   1'b1, 1'b1},
        '{1282,  15'd0,   1'b0, 1'b1},
        '{1314,  15'd0,   1'b0, 1'b1},
        '{1316,  15'd0,   1'b0, 1'b0},
        '{1506,  15'd0,   1'b0, 1'b0},
        '{1508,  15'd0,   1'b0, 1'b1},
        '{6410,  15'd161, 1'b1, 1'b1},
        '{12480, 15'd319, 1'b1, 1'b1},
        '{12802, 15'd0,   1'b0, 1'b1}
    };

    function automatic out_t rst_val();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Expected outputs after clk edge e since release (0 = in reset).
    // Tick n happens on edge 2n; the read stage shows pixel n-1 and
    // the DAC stage shows pixel n-2, pixels numbered in raster order.
    function automatic out_t exp_at(int e);
        out_t o;
        int n, q, p, h, v;
        o = rst_val();
        if (e == 0) return o;
        n = e / 2;
        o.vclk = (e % 2) == 1;
        if (n >= 1) begin
            q = n - 1;
            h = q % LINE;
            v = (q / LINE) % LINES;
            if (h < 640 && v < V_ACT) begin
                o.en   = 1'b1;
                o.addr = 15'((v / 4) * 160 + h / 4);
            end
        end
        if (n >= 2) begin
            p = n - 2;
            h = p % LINE;
            v = (p / LINE) % LINES;
            o.hs = !(h >= 656 && h <= 751);
            o.vs = !(v == 9 || v == 10);
            if (h < 640 && v < V_ACT) begin
                o.blank_n = 1'b1;
                if (h / 4 == 1 && v / 4 == 1) begin
                    o.r = 10'h3FF;
                end else begin
                    o.g = 10'h3FF;
                    o.b = 10'h3FF;
                end
            end
        end
        o.ft = (e % 2 == 0) && (n % FRAME == V_ACT * LINE);
        return o;
    endfunction

    function automatic out_t act();
        out_t o;
        o.vclk    = VGA_CLK;
        o.addr    = fb_addr;
        o.en      = fb_rd_en;
        o.hs      = VGA_HS;
        o.vs      = VGA_VS;
        o.blank_n = VGA_BLANK_N;
        o.sync_n  = VGA_SYNC_N;
        o.r       = VGA_R;
        o.g       = VGA_G;
        o.b       = VGA_B;
        o.ft      = frame_tick;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] x, input int e);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h expected=%h", nm, e, a, x);
        end
    endtask

    // Reference side: one expectation per clk edge.
    always @(posedge clk) begin
        if (!resetn) e_cnt = 0;
        else         e_cnt++;
        sb.push_back('{e_cnt, exp_at(e_cnt)});
    end

    // Monitor side: compare DAC/read outputs half a clk after each edge.
    always @(negedge clk) begin
        sb_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            chk("raster", 64'(act()), 64'(it.x), it.e);
            for (int i = 0; i < 10; i++) begin
                if (tbl[i].e == it.e) begin
                    chk("directed", {47'd0, fb_addr, fb_rd_en, VGA_HS},
                        {47'd0, tbl[i].a, tbl[i].en, tbl[i].hs}, it.e);
                end
            end
            if (frame_tick === 1'b1) ft_seen++;
        end
    end

    initial begin
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        #3 resetn = 1'b1;
        // Two full frames plus 5 lines and 300 pixels: counters (300,5).
        repeat (2 * (2 * FRAME + 5 * LINE + 300)) @(negedge clk);
        chk("frame_ticks", 64'(ft_seen), 64'd2, -1);
        #3 resetn = 1'b0;
        #1 chk("async_reset", 64'(act()), 64'(rst_val()), -1);
        repeat (3) @(negedge clk);
        #3 resetn = 1'b1;
        repeat (13000) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
